// File: rtl/sw_input_port_pkg.sv
// Shared definitions for the operator switch input port.
// Holds the press-tracking state type and a counter-width helper.
package sw_input_port_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESSED = 1'b1
    } press_state_t;

    // Bits needed for a counter running 0 .. cycles-1 (never narrower than 1).
    function automatic int cnt_width(input int cycles);
        return (cycles <= 1) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/sw_input_port_btn_debounce.sv
// Two-flop synchronizer plus stability-counter debouncer for one button.
// db_change is high during the cycle whose closing edge toggles out_db.
module btn_debounce
    import sw_input_port_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic in_raw,
    output logic out_db,
    output logic db_change
);

    localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             in_sync;
    logic [CNT_W-1:0] stable_cnt;

    // Bring the asynchronous button level into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            in_sync <= 1'b0;
        end else begin
            sync_q1 <= in_raw;
            in_sync <= sync_q1;
        end
    end

    assign db_change = (in_sync != out_db) && (stable_cnt == CNT_MAX);

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_cnt <= '0;
            out_db     <= 1'b0;
        end else if (in_sync == out_db) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_MAX) begin
            stable_cnt <= '0;
            out_db     <= ~out_db;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sw_input_port.sv
// Operator input port: debounced commit button captures the switches into a
// word offered to the CPU with a valid/read handshake.
// Optional build macro SW_INPUT_AUTO_REPEAT_EN adds periodic re-capture while held.
module sw_input_port
    import sw_input_port_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int SW_WIDTH        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_raw,
    input  logic [SW_WIDTH-1:0]   sw_raw,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  overrun,
    output logic                  btn_db
);

    logic [SW_WIDTH-1:0] sw_q1;
    logic [SW_WIDTH-1:0] sw_sync;
    logic                db_change;
    logic                rep_hit;
    logic                capture;
    press_state_t        state_q;
    press_state_t        state_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk      (clk),
        .rst      (rst),
        .in_raw   (btn_raw),
        .out_db   (btn_db),
        .db_change(db_change)
    );

    // Switch synchronizer; its latency matches the button path so a press sees settled switches.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_q1   <= '0;
            sw_sync <= '0;
        end else begin
            sw_q1   <= sw_raw;
            sw_sync <= sw_q1;
        end
    end

`ifdef SW_INPUT_AUTO_REPEAT_EN
    localparam int              REP_W   = cnt_width(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt;

    // Repeat timer runs only while staying in PRESSED; entry and exit both restart it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt <= '0;
        end else if ((state_q != PRESSED) || (state_d != PRESSED)) begin
            rep_cnt <= '0;
        end else if (rep_cnt == REP_MAX) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end

    assign rep_hit = (rep_cnt == REP_MAX);
`else
    // Without auto-repeat there is never a repeat capture; REPEAT_CYCLES is referenced
    // only so the parameter list stays identical between builds.
    assign rep_hit = (REPEAT_CYCLES < 0);
`endif

    // Press-tracking state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and capture strobe; a release edge takes priority over a repeat tick.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (db_change) begin
                    state_d = PRESSED;
                    capture = 1'b1;
                end
            end
            PRESSED: begin
                if (db_change) begin
                    state_d = IDLE;
                end else if (rep_hit) begin
                    capture = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Word register and handshake; a capture beats a same-edge read.
    always_ff @(posedge clk) begin
        if (rst) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (capture) begin
            data  <= DATA_WIDTH'(sw_sync);
            valid <= 1'b1;
            if (valid && !rd) begin
                overrun <= 1'b1;
            end
        end else if (rd && valid) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: doc/sw_input_port.md
Name: sw_input_port

Overview:
Operator input port for the CPU's IN path.
- Synchronizes the switches and one commit button, and debounces the button.
- On each debounced press, captures the switch value as one zero-extended DATA_WIDTH word.
- Presents the word to the consumer (CPU input side) with a valid/read handshake.
- Output displays and LEDs drive data out of the design; this block brings operator data in.

Parameters:
DATA_WIDTH, 16, width of delivered word; must be >= SW_WIDTH
SW_WIDTH, 4, number of switch bits captured
DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required to accept a button level change (10 ms at 50 MHz); must be >= 1
REPEAT_CYCLES, 25000000, auto-repeat period in clk cycles (used only with SW_INPUT_AUTO_REPEAT_EN)

Ports:
clk  input  1  system clock; single clock domain, all logic on rising edge
rst  input  1  synchronous reset, active-high
btn_raw  input  1  asynchronous commit button, 1 = pressed
sw_raw  input  SW_WIDTH  asynchronous switch inputs
rd  input  1  consumer read strobe, synchronous to clk, one cycle per word
data  output  DATA_WIDTH  captured word: {zeros, sw_sync}
valid  output  1  data holds an unread word
overrun  output  1  sticky: a word was overwritten before being read
btn_db  output  1  debounced button level, for LED/debug

Behaviour:
Reset (rst=1 at clk edge): clears all of the following to 0.
- data, valid, overrun, btn_db.
- Synchronizer flops and the debounce counter.
- Repeat counter; FSM returns to IDLE.

Synchronizer:
- Two flops each on btn_raw and every sw_raw bit.
- The synchronized values are btn_sync and sw_sync.

Debounce:
- Counter increments on every cycle with btn_sync != btn_db.
- Counter clears to 0 on any cycle with btn_sync == btn_db.
- When the counter equals DEBOUNCE_CYCLES-1 and btn_sync still differs, btn_db toggles at that edge and the counter clears.
- A glitch shorter than DEBOUNCE_CYCLES never toggles btn_db.

FSM:
- IDLE (btn_db=0) -> PRESSED on the edge where btn_db goes 0->1. That edge is a capture.
- PRESSED -> IDLE when btn_db goes 1->0. Release causes no capture.

Capture:
- Performed on the same edge as the IDLE->PRESSED transition.
- data <= zero-extended sw_sync as sampled at that edge.
- valid <= 1.

Latency:
- btn_raw held high continuously from before edge k: btn_db is high after edge k+1+DEBOUNCE_CYCLES.
- valid is high after that same edge.

Read:
- rd=1 with valid=1: valid clears at that edge; data holds its value.
- rd=1 with valid=0: ignored, no state change.

Boundary cases:
- Capture while valid=1 and rd=0: data is overwritten, valid stays 1, overrun <= 1.
- Capture and rd on the same edge: capture wins. New data loaded, valid stays 1, overrun unchanged.
- overrun clears only on rst.
- Switch changes while no capture is occurring do not affect data.
- rst asserted mid-debounce or in PRESSED: the in-progress press is discarded. A button still held after rst must re-debounce from btn_db=0 and then produces one capture.

Optional Feature:
Macro: SW_INPUT_AUTO_REPEAT_EN.
- Defined: while in PRESSED, a repeat counter increments every cycle. On reaching REPEAT_CYCLES-1 it clears and performs a capture, with the same capture and overrun rules as above. The repeat counter clears on entry to PRESSED, on exit from PRESSED, and on rst.
- Not defined: exactly one capture per debounced press. There is no repeat counter, and REPEAT_CYCLES is ignored.

Decomposition:
Shared package contains:
- FSM state typedef (IDLE, PRESSED).
- Counter-width constant helper (clog2 of DEBOUNCE_CYCLES / REPEAT_CYCLES).

Sub-module btn_debounce contains:
- The 2-flop synchronizer and the debounce counter.
- Parameter DEBOUNCE_CYCLES; ports clk, rst, in_raw, out_db.

Switch synchronization, FSM, capture and handshake stay in sw_input_port.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8, SW_WIDTH=4, DATA_WIDTH=16.
1. Press: sw_raw=4'hA, btn_raw 0->1 held -> valid=1 and data=16'h000A exactly 5 edges after btn_raw first sampled high. Then rd pulse -> valid=0, data stays 16'h000A.
2. Glitch: btn_raw high for 3 cycles then low -> btn_db, valid and data never change.
3. Overrun: press with sw=4'h3, release, then press with sw=4'h5, no rd -> data=16'h0005, valid=1, overrun=1. rd pulse -> valid=0, overrun stays 1.
4. Simultaneous: rd asserted on the exact capture edge of a second press (sw=4'h7) -> data=16'h0007, valid=1, overrun=0.
5. Reset mid-operation: rst during PRESSED with valid=1 -> next cycle data=0, valid=0, overrun=0, btn_db=0. Button still held -> a new capture occurs 5 cycles after rst drops.
6. SW_INPUT_AUTO_REPEAT_EN defined, button held 30 cycles with rd after each capture -> captures at debounce edge then every 8 cycles (4 total). Macro undefined -> exactly 1 capture.
